// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone classic slave GPIO controller.
//
// Single-cycle registered ack, GPIO_WIDTH output / output-enable pins,
// two-flop input synchronizer and a sticky edge-triggered interrupt.
//
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   wbs_*            Wishbone slave (cyc, stb, we, addr, wdata, sel, rdata, ack)
//   gpio_in_i        asynchronous pin inputs
//   gpio_out_o       pin output values (OUT register)
//   gpio_oe_o        pin output enables, 1 = drive (DIR register)
//   irq_o            level interrupt, |(IRQ_STAT & IRQ_EN), registered
//
// Register map (word index = addr[7:2]):
//   0 OUT, 1 DIR, 2 IN (RO), 3 IRQ_EN, 4 IRQ_TYPE (1 = rise, 0 = fall),
//   5 IRQ_STAT (W1C), 6 OUT_SET (WO), 7 OUT_CLR (WO); others read 0.

module wb_gpio #(
    parameter int unsigned WB_AD_WIDTH  = 32,
    parameter int unsigned WB_DAT_WIDTH = 32,
    parameter int unsigned GPIO_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [WB_AD_WIDTH-1:0]    wbs_addr_i,
    input  logic [WB_DAT_WIDTH-1:0]   wbs_wdata_i,
    input  logic [WB_DAT_WIDTH/8-1:0] wbs_sel_i,
    output logic [WB_DAT_WIDTH-1:0]   wbs_rdata_o,
    output logic                      wbs_ack_o,
    input  logic [GPIO_WIDTH-1:0]     gpio_in_i,
    output logic [GPIO_WIDTH-1:0]     gpio_out_o,
    output logic [GPIO_WIDTH-1:0]     gpio_oe_o,
    output logic                      irq_o
);

    localparam logic [5:0] AddrOut     = 6'd0;
    localparam logic [5:0] AddrDir     = 6'd1;
    localparam logic [5:0] AddrIn      = 6'd2;
    localparam logic [5:0] AddrIrqEn   = 6'd3;
    localparam logic [5:0] AddrIrqType = 6'd4;
    localparam logic [5:0] AddrIrqStat = 6'd5;
    localparam logic [5:0] AddrOutSet  = 6'd6;
    localparam logic [5:0] AddrOutClr  = 6'd7;

    typedef enum logic [0:0] {StIdle, StAck} state_e;

    state_e state_q, state_d;

    logic xfer_en, wr_en, rd_en;

    logic [GPIO_WIDTH-1:0] out_q, out_d;
    logic [GPIO_WIDTH-1:0] dir_q, dir_d;
    logic [GPIO_WIDTH-1:0] en_q, en_d;
    logic [GPIO_WIDTH-1:0] type_q, type_d;
    logic [GPIO_WIDTH-1:0] stat_q, stat_d;
    logic [GPIO_WIDTH-1:0] s1_q, s2_q, prev_q;
    logic [WB_DAT_WIDTH-1:0] rdata_q, rdata_d;
    logic irq_q, irq_d;

    logic [WB_DAT_WIDTH-1:0] byte_mask, wdata_m;
    logic [GPIO_WIDTH-1:0]   lane_mask, wr_bits, edge_hit;
    logic [5:0]              reg_idx;
    logic                    unused_bits;

    // ---------------------------------------------------------------------
    // Bus FSM: state register / next state / outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (wbs_cyc_i && wbs_stb_i) state_d = StAck;
            StAck:   state_d = StIdle;  // stb ignored here, so back-to-back gets a gap
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        xfer_en   = (state_q == StIdle) && wbs_cyc_i && wbs_stb_i;
        wr_en     = xfer_en && wbs_we_i;
        rd_en     = xfer_en && !wbs_we_i;
        wbs_ack_o = (state_q == StAck);
    end

    // ---------------------------------------------------------------------
    // Write data conditioning
    // ---------------------------------------------------------------------
    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < WB_DAT_WIDTH / 8; i++) begin
            byte_mask[i*8 +: 8] = {8{wbs_sel_i[i]}};
        end
    end

    // Masked-off lanes look like zero data, which is exactly what the
    // set/clear/W1C registers need.
    assign wdata_m   = wbs_wdata_i & byte_mask;
    assign wr_bits   = wdata_m[GPIO_WIDTH-1:0];
    assign lane_mask = byte_mask[GPIO_WIDTH-1:0];
    assign reg_idx   = wbs_addr_i[7:2];

    // Upper address/data bits are decoded by the interconnect or have no pins.
    assign unused_bits = ^{wdata_m, byte_mask, wbs_addr_i};

    // ---------------------------------------------------------------------
    // Edge detection on the synchronized inputs
    // ---------------------------------------------------------------------
    assign edge_hit = (type_q & s2_q & ~prev_q) | (~type_q & ~s2_q & prev_q);

    // ---------------------------------------------------------------------
    // Register next state
    // ---------------------------------------------------------------------
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        en_d   = en_q;
        type_d = type_q;
        // New edges are OR-ed in after any W1C so a coincident set wins.
        stat_d = stat_q | edge_hit;
        if (wr_en) begin
            case (reg_idx)
                AddrOut:     out_d  = (out_q & ~lane_mask) | wr_bits;
                AddrDir:     dir_d  = (dir_q & ~lane_mask) | wr_bits;
                AddrIrqEn:   en_d   = (en_q & ~lane_mask) | wr_bits;
                AddrIrqType: type_d = (type_q & ~lane_mask) | wr_bits;
                AddrIrqStat: stat_d = (stat_q & ~wr_bits) | edge_hit;
                AddrOutSet:  out_d  = out_q | wr_bits;
                AddrOutClr:  out_d  = out_q & ~wr_bits;
                default:     ;
            endcase
        end
    end

    // Read data is only non-zero in the ack cycle.
    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (reg_idx)
                AddrOut:     rdata_d[GPIO_WIDTH-1:0] = out_q;
                AddrDir:     rdata_d[GPIO_WIDTH-1:0] = dir_q;
                AddrIn:      rdata_d[GPIO_WIDTH-1:0] = s2_q;
                AddrIrqEn:   rdata_d[GPIO_WIDTH-1:0] = en_q;
                AddrIrqType: rdata_d[GPIO_WIDTH-1:0] = type_q;
                AddrIrqStat: rdata_d[GPIO_WIDTH-1:0] = stat_q;
                default:     rdata_d = '0;
            endcase
        end
    end

    assign irq_d = |(stat_q & en_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q   <= '0;
            dir_q   <= '0;
            en_q    <= '0;
            type_q  <= '0;
            stat_q  <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            type_q  <= type_d;
            stat_q  <= stat_d;
            s1_q    <= gpio_in_i;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign wbs_rdata_o = rdata_q;
    assign gpio_out_o  = out_q;
    assign gpio_oe_o   = dir_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_wb_gpio.sv
// Directed testbench for wb_gpio with hand-computed expected values.

module tb_wb_gpio;

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  sel;
    logic        ack;
    logic [15:0] gpio_in, gpio_out, gpio_oe;
    logic        irq;

    int n_checks;
    int n_errors;
    logic        irq_at_ack;
    logic [31:0] rd_tmp;

    wb_gpio #(
        .WB_AD_WIDTH (32),
        .WB_DAT_WIDTH(32),
        .GPIO_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_addr_i (addr),
        .wbs_wdata_i(wdata),
        .wbs_sel_i  (sel),
        .wbs_rdata_o(rdata),
        .wbs_ack_o  (ack),
        .gpio_in_i  (gpio_in),
        .gpio_out_o (gpio_out),
        .gpio_oe_o  (gpio_oe),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r);
        check("ack_idle", {31'd0, ack}, 32'd0);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        @(posedge clk); #1;
        check("ack_hi", {31'd0, ack}, 32'd1);
        r = rdata;
        irq_at_ack = irq;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wdata = '0; sel = '0;
        @(posedge clk); #1;
        check("ack_lo", {31'd0, ack}, 32'd0);
        check("rdata_lo", rdata, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        xfer(1'b1, a, d, s, dummy);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        xfer(1'b0, a, 32'd0, 4'h0, r);
        check(tag, r, exp);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; sel = '0; gpio_in = '0; irq_at_ack = 1'b0;

        // Reset state
        tick(3);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_out", {16'd0, gpio_out}, 32'd0);
        check("rst_oe", {16'd0, gpio_oe}, 32'd0);
        rst = 1'b1;
        tick(1);

        // Every offset, including an unmapped one, reads 0
        for (int i = 0; i <= 8; i++) rd(i * 4, 32'd0, "rst_read");

        // OUT with byte lanes, then set / clear
        wr(32'h00, 32'h0000_A5A5, 4'b0001);
        check("out_pin_a5", {16'd0, gpio_out}, 32'h0000_00A5);
        rd(32'h00, 32'h0000_00A5, "out_rd_a5");
        wr(32'h18, 32'h0000_0100, 4'hF);
        check("out_pin_set", {16'd0, gpio_out}, 32'h0000_01A5);
        rd(32'h00, 32'h0000_01A5, "out_rd_set");
        wr(32'h1C, 32'h0000_0005, 4'hF);
        check("out_pin_clr", {16'd0, gpio_out}, 32'h0000_01A0);
        rd(32'h00, 32'h0000_01A0, "out_rd_clr");
        rd(32'h18, 32'd0, "outset_rd0");

        // DIR and bits beyond the pin count
        wr(32'h04, 32'h0000_FFFF, 4'hF);
        check("oe_pin", {16'd0, gpio_oe}, 32'h0000_FFFF);
        rd(32'h04, 32'h0000_FFFF, "dir_rd");
        wr(32'h04, 32'h0001_0000, 4'hF);
        rd(32'h04, 32'h0000_0000, "dir_bit16");
        wr(32'h04, 32'h0000_FFFF, 4'hF);

        // Rising edge on pin 0: irq three edges after the pin change
        wr(32'h0C, 32'h1, 4'hF);
        wr(32'h10, 32'h1, 4'hF);
        gpio_in[0] = 1'b1;
        tick(1); check("irq_e0", {31'd0, irq}, 32'd0);
        tick(1); check("irq_e1", {31'd0, irq}, 32'd0);
        tick(1); check("irq_e2", {31'd0, irq}, 32'd0);
        tick(1); check("irq_e3", {31'd0, irq}, 32'd1);
        rd(32'h08, 32'h1, "in_rd");
        rd(32'h14, 32'h1, "stat_rise");
        wr(32'h14, 32'h1, 4'hF);
        check("w1c_irq_at_ack", {31'd0, irq_at_ack}, 32'd1);
        check("w1c_irq_after", {31'd0, irq}, 32'd0);
        // Falling edge is not selected for pin 0
        gpio_in[0] = 1'b0;
        tick(4);
        rd(32'h14, 32'h0, "stat_fall");
        check("irq_fall", {31'd0, irq}, 32'd0);

        // Pin 3 edge while disabled, then enable, then clear
        wr(32'h10, 32'h9, 4'hF);
        gpio_in[3] = 1'b1;
        tick(4);
        rd(32'h14, 32'h8, "stat_pin3");
        check("irq_pin3_dis", {31'd0, irq}, 32'd0);
        wr(32'h0C, 32'h9, 4'hF);
        check("en_irq_at_ack", {31'd0, irq_at_ack}, 32'd0);
        check("en_irq_after", {31'd0, irq}, 32'd1);
        wr(32'h14, 32'h8, 4'hF);
        check("clr3_irq", {31'd0, irq}, 32'd0);
        rd(32'h14, 32'h0, "stat_clr3");

        // W1C coincident with a new rising edge: set wins
        gpio_in[0] = 1'b1;
        tick(4);
        check("irq_pin0_again", {31'd0, irq}, 32'd1);
        gpio_in[0] = 1'b0;
        tick(4);
        gpio_in[0] = 1'b1;
        tick(2);
        wr(32'h14, 32'h1, 4'hF);
        check("setwins_irq", {31'd0, irq}, 32'd1);
        rd(32'h14, 32'h1, "setwins_stat");

        // Reset asserted during an ACK cycle
        gpio_in = '0;
        tick(4);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h04; wdata = 32'h0000_1234; sel = 4'hF;
        @(posedge clk); #1;
        check("rstack_hi", {31'd0, ack}, 32'd1);
        check("rstack_oe", {16'd0, gpio_oe}, 32'h0000_1234);
        rst = 1'b0;
        addr = 32'h00; wdata = 32'h0000_FFFF;
        @(posedge clk); #1;
        check("rstack_ack", {31'd0, ack}, 32'd0);
        check("rstack_oe0", {16'd0, gpio_oe}, 32'd0);
        @(posedge clk); #1;
        check("rstack_out0", {16'd0, gpio_out}, 32'd0);
        check("rstack_irq0", {31'd0, irq}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wdata = '0; sel = '0;
        rst = 1'b1;
        tick(1);
        for (int i = 0; i <= 5; i++) rd(i * 4, 32'd0, "post_rst_read");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
